pass_change_writer: RTL and testbench

PASS_CHANGE_WRITER -- requirements
Module: pass_change_writer

---
 rtl/pass_change_writer.sv | 147 ++++++++++++++
 tb/tb_pass_change_writer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pass_change_writer.sv
// Password-change sequencer: start press, three new digits, three confirm digits, then commit.
// Latency: stored_pass and pass_wr update on the edge that samples the third matching confirm press.
// Backpressure: none; presses are taken when they arrive and ignored outside the capture phases.
module pass_change_writer #(
    parameter logic [11:0] DEFAULT_PASS = 12'h777,
    parameter int          TIMEOUT      = 200,
    parameter int          ERR_CYCLES   = 16
) (
    input  logic        clk,
    input  logic        lock_rst_2,
    input  logic        mode_2,
    input  logic        unlocked,
    input  logic [3:0]  mod10_out,
    input  logic        enter_2,
    output logic [11:0] stored_pass,
    output logic        pass_wr,
    output logic        err_2,
    output logic [2:0]  led_state,
    output logic [1:0]  digit_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int EW = $clog2(ERR_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRST,
        S_CONFIRM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state, state_nxt;
    logic          enter_q;
    logic          armed;
    logic [11:0]   first_buf;
    logic [7:0]    conf_buf;
    logic [TW-1:0] tmo_cnt;
    logic [EW-1:0] err_cnt;

    logic          press;
    logic          digit_ok;
    logic          abort;
    logic          last_digit;
    logic [11:0]   first_shift;
    logic [11:0]   conf_shift;

    // armed blocks a button still held when reset releases from counting as a press
    assign press       = enter_2 & ~enter_q & armed;
    assign digit_ok    = press && (mod10_out <= 4'd9);
    assign abort       = ~mode_2 | ~unlocked;
    assign last_digit  = (digit_cnt == 2'd2);
    assign first_shift = {first_buf[7:0], mod10_out};
    assign conf_shift  = {conf_buf, mod10_out};

    always_comb begin
        state_nxt = state;
        pass_wr   = 1'b0;
        err_2     = 1'b0;
        led_state = 3'b000;
        case (state)
            S_IDLE: begin
                led_state = 3'b001;
                if (press && mode_2 && unlocked)
                    state_nxt = S_FIRST;
            end
            S_FIRST, S_CONFIRM: begin
                led_state = (state == S_FIRST) ? 3'b010 : 3'b100;
                if (abort)
                    state_nxt = S_IDLE;
                else if (digit_ok && last_digit) begin
                    if (state == S_FIRST)
                        state_nxt = S_CONFIRM;
                    else
                        state_nxt = (conf_shift == first_buf) ? S_DONE : S_ERROR;
                end else if (!press && tmo_cnt <= TW'(1))
                    state_nxt = S_ERROR;
            end
            S_DONE: begin
                pass_wr   = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERROR: begin
                err_2 = 1'b1;
                if (err_cnt == '0)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge lock_rst_2) begin
        if (lock_rst_2) begin
            state       <= S_IDLE;
            stored_pass <= DEFAULT_PASS;
            first_buf   <= '0;
            conf_buf    <= '0;
            digit_cnt   <= '0;
            enter_q     <= 1'b0;
            armed       <= 1'b0;
            tmo_cnt     <= TW'(TIMEOUT);
            err_cnt     <= EW'(ERR_CYCLES - 1);
        end else begin
            state   <= state_nxt;
            enter_q <= enter_2;
            if (!enter_2)
                armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    tmo_cnt <= TW'(TIMEOUT);
                    if (state_nxt == S_FIRST) begin
                        first_buf <= '0;
                        conf_buf  <= '0;
                        digit_cnt <= '0;
                    end
                end
                S_FIRST, S_CONFIRM: begin
                    if (abort) begin
                        first_buf <= '0;
                        conf_buf  <= '0;
                        digit_cnt <= '0;
                    end else begin
                        if (press)
                            tmo_cnt <= TW'(TIMEOUT);
                        else
                            tmo_cnt <= tmo_cnt - TW'(1);
                        if (digit_ok) begin
                            if (state == S_FIRST)
                                first_buf <= first_shift;
                            else
                                conf_buf <= conf_shift[7:0];
                            digit_cnt <= last_digit ? 2'd0 : digit_cnt + 2'd1;
                        end
                        if (state_nxt == S_DONE)
                            stored_pass <= first_buf;
                    end
                end
                S_ERROR: err_cnt <= err_cnt - EW'(1);
                default: ;
            endcase
            // a timeout can leave a partial count behind; ERROR always shows zero digits
            if (state_nxt == S_ERROR && state != S_ERROR) begin
                err_cnt   <= EW'(ERR_CYCLES - 1);
                digit_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pass_change_writer.sv
// Bench for pass_change_writer: digit-queue reference model checked every cycle plus directed literal checks.
module tb_pass_change_writer;
    localparam int TIMEOUT    = 200;
    localparam int ERR_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic        unl = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic        enter = 1'b0;
    logic [11:0] stored_pass;
    logic        pass_wr;
    logic        err_2;
    logic [2:0]  led_state;
    logic [1:0]  digit_cnt;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    int err_cyc = 0;
    bit chk_en = 1'b0;

    pass_change_writer #(
        .DEFAULT_PASS(12'h777),
        .TIMEOUT(TIMEOUT),
        .ERR_CYCLES(ERR_CYCLES)
    ) dut (
        .clk(clk),
        .lock_rst_2(rst),
        .mode_2(mode),
        .unlocked(unl),
        .mod10_out(digit),
        .enter_2(enter),
        .stored_pass(stored_pass),
        .pass_wr(pass_wr),
        .err_2(err_2),
        .led_state(led_state),
        .digit_cnt(digit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phases 0 idle, 1 first, 2 confirm, 3 done, 4 error
    int          m_phase = 0;
    int          fq[$];
    int          cq[$];
    int          quiet = 0;
    int          err_left = 0;
    logic [11:0] m_pass = 12'h777;
    bit          m_prev = 1'b1;
    bit          pr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; fq.delete(); cq.delete();
            quiet = 0; err_left = 0; m_pass = 12'h777; m_prev = 1'b1;
        end else begin
            pr = enter && !m_prev;
            m_prev = enter;
            case (m_phase)
                0: if (pr && mode && unl) begin
                    m_phase = 1; fq.delete(); cq.delete(); quiet = 0;
                end
                1, 2: begin
                    if (!mode || !unl) begin
                        m_phase = 0; fq.delete(); cq.delete();
                    end else if (pr) begin
                        quiet = 0;
                        if (digit < 4'd10) begin
                            if (m_phase == 1) begin
                                fq.push_back(int'(digit));
                                if (fq.size() == 3) m_phase = 2;
                            end else begin
                                cq.push_back(int'(digit));
                                if (cq.size() == 3) begin
                                    if (cq[0] == fq[0] && cq[1] == fq[1] && cq[2] == fq[2]) begin
                                        m_pass = 12'(fq[0] * 256 + fq[1] * 16 + fq[2]);
                                        m_phase = 3;
                                    end else begin
                                        m_phase = 4; err_left = ERR_CYCLES;
                                    end
                                end
                            end
                        end
                    end else begin
                        quiet++;
                        if (quiet == TIMEOUT) begin
                            m_phase = 4; err_left = ERR_CYCLES;
                        end
                    end
                end
                3: m_phase = 0;
                default: begin
                    err_left--;
                    if (err_left == 0) m_phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        wr_count += int'(pass_wr);
        err_cyc  += int'(err_2);
        if (chk_en) begin
            check("model stored_pass", 32'(stored_pass), 32'(m_pass));
            check("model pass_wr", 32'(pass_wr), (m_phase == 3) ? 32'd1 : 32'd0);
            check("model err_2", 32'(err_2), (m_phase == 4) ? 32'd1 : 32'd0);
            check("model led_state", 32'(led_state),
                  (m_phase == 0) ? 32'd1 : (m_phase == 1) ? 32'd2 : (m_phase == 2) ? 32'd4 : 32'd0);
            check("model digit_cnt", 32'(digit_cnt),
                  (m_phase == 1) ? 32'(fq.size()) : (m_phase == 2) ? 32'(cq.size()) : 32'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [3:0] d);
        digit = d;
        enter = 1'b1;
        tick(3);
        enter = 1'b0;
        tick(2);
    endtask

    initial begin
        tick(2);
        chk_en = 1'b1;
        check("reset stored_pass", 32'(stored_pass), 32'h777);
        check("reset led_state", 32'(led_state), 32'h1);
        check("reset pass_wr", 32'(pass_wr), 32'h0);
        check("reset err_2", 32'(err_2), 32'h0);
        rst = 1'b0;
        tick(2);

        // successful change to 456, with pass_wr timing around the final press
        mode = 1'b1; unl = 1'b1;
        wr_count = 0;
        press(4'd0);
        check("start led", 32'(led_state), 32'h2);
        press(4'd4); press(4'd5); press(4'd6);
        check("confirm led", 32'(led_state), 32'h4);
        press(4'd4); press(4'd5);
        digit = 4'd6; enter = 1'b1;
        @(negedge clk);
        check("wr before edge", 32'(pass_wr), 32'h0);
        @(negedge clk);
        check("wr after edge", 32'(pass_wr), 32'h1);
        check("new pass", 32'(stored_pass), 32'h456);
        @(negedge clk);
        check("wr one cycle", 32'(pass_wr), 32'h0);
        tick(2); enter = 1'b0; tick(3);
        check("wr pulses", 32'(wr_count), 32'd1);
        check("back idle", 32'(led_state), 32'h1);

        // mismatch: error window, press during error ignored
        wr_count = 0; err_cyc = 0;
        press(4'd0);
        press(4'd1); press(4'd2); press(4'd3);
        press(4'd1); press(4'd2); press(4'd4);
        press(4'd7);
        tick(25);
        check("mismatch err cycles", 32'(err_cyc), 32'(ERR_CYCLES));
        check("mismatch no wr", 32'(wr_count), 32'd0);
        check("mismatch pass kept", 32'(stored_pass), 32'h456);

        // long hold counts once, out-of-range digit ignored, then timeout
        err_cyc = 0;
        press(4'd0);
        press(4'd1);
        check("cnt after 1", 32'(digit_cnt), 32'd1);
        digit = 4'd2; enter = 1'b1; tick(20); enter = 1'b0; tick(2);
        check("hold one press", 32'(digit_cnt), 32'd2);
        press(4'hC);
        check("bad digit ignored", 32'(digit_cnt), 32'd2);
        tick(TIMEOUT - 10);
        check("before timeout", 32'(err_2), 32'h0);
        tick(10);
        check("after timeout", 32'(err_2), 32'h1);
        tick(20);
        check("timeout err cycles", 32'(err_cyc), 32'(ERR_CYCLES));
        check("timeout idle", 32'(led_state), 32'h1);

        // unlocked drop aborts without error or write
        err_cyc = 0; wr_count = 0;
        press(4'd0); press(4'd1); press(4'd2);
        unl = 1'b0; tick(1);
        check("abort idle", 32'(led_state), 32'h1);
        tick(3);
        check("abort no err", 32'(err_cyc), 32'd0);
        check("abort no wr", 32'(wr_count), 32'd0);
        unl = 1'b1; tick(1);

        // mode drop in confirm also aborts
        press(4'd0); press(4'd1); press(4'd2); press(4'd3); press(4'd1);
        mode = 1'b0; tick(2);
        check("mode abort idle", 32'(led_state), 32'h1);
        mode = 1'b1; tick(1);

        // commit 123, then reset mid-confirm with button held across release
        press(4'd0); press(4'd1); press(4'd2); press(4'd3);
        press(4'd1); press(4'd2); press(4'd3);
        check("pass 123", 32'(stored_pass), 32'h123);
        press(4'd0); press(4'd4); press(4'd5); press(4'd6); press(4'd4);
        enter = 1'b1; digit = 4'd5;
        rst = 1'b1; tick(1);
        check("rst pass", 32'(stored_pass), 32'h777);
        check("rst led", 32'(led_state), 32'h1);
        rst = 1'b0; tick(3);
        check("held press ignored", 32'(led_state), 32'h1);
        enter = 1'b0; tick(2);
        press(4'd0);
        check("fresh start", 32'(led_state), 32'h2);
        mode = 1'b0; tick(2);

        // locked: presses do nothing
        mode = 1'b1; unl = 1'b0; wr_count = 0;
        press(4'd0); press(4'd3); press(4'd3);
        check("locked idle", 32'(led_state), 32'h1);
        check("locked cnt", 32'(digit_cnt), 32'd0);
        check("locked no wr", 32'(wr_count), 32'd0);
        check("locked pass", 32'(stored_pass), 32'h777);

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
